// File: rtl/fp_minmax128_pkg.sv
// Shared FP128 field positions, min/max opcode encoding and NaN helpers.
package fp_minmax128_pkg;

  localparam int unsigned FP128 = 128;
  localparam int unsigned EMSB  = 126;
  localparam int unsigned FMSB  = 111;

  typedef enum logic [2:0] {
    OP_MIN    = 3'd0,
    OP_MAX    = 3'd1,
    OP_MINNUM = 3'd2,
    OP_MAXNUM = 3'd3,
    OP_MINMAG = 3'd4,
    OP_MAXMAG = 3'd5
  } fp_minmax_op_t;

  localparam logic [FP128-1:0] FP128_QNAN = {1'b0, 15'h7FFF, 1'b1, 111'd0};

  function automatic logic fp128_is_nan(input logic [FP128-1:0] x);
    return (&x[EMSB:FMSB+1]) && (|x[FMSB:0]);
  endfunction

  function automatic logic [FP128-1:0] fp128_quiet(input logic [FP128-1:0] x);
    logic [FP128-1:0] q;
    q       = x;
    q[FMSB] = 1'b1;
    return q;
  endfunction

endpackage

// File: rtl/fp_minmax128_if.sv
// Valid/ready operand and result channels of the FP128 min/max selector.
interface fp_minmax128_if #(parameter int unsigned TAGW = 4);
  import fp_minmax128_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic [2:0]       op;
  logic [FP128-1:0] a;
  logic [FP128-1:0] b;
  logic [15:0]      cmp;
  logic [TAGW-1:0]  tag;
  logic             m_valid;
  logic             m_ready;
  logic [FP128-1:0] o;
  logic [TAGW-1:0]  o_tag;
  logic             o_invalid;

  modport master (
    output s_valid, op, a, b, cmp, tag, m_ready,
    input  s_ready, m_valid, o, o_tag, o_invalid
  );

  modport slave (
    input  s_valid, op, a, b, cmp, tag, m_ready,
    output s_ready, m_valid, o, o_tag, o_invalid
  );

endinterface

// File: rtl/fp_minmax128_sel.sv
// Combinational select stage: ordered min/max/mag choice, NaN propagation, invalid flag.
module fp_minmax_sel128
  import fp_minmax128_pkg::*;
(
  input  fp_minmax_op_t    op,
  input  logic [FP128-1:0] a,
  input  logic [FP128-1:0] b,
  input  logic [4:0]       cmp,
  input  logic             nan_a,
  input  logic             nan_b,
  input  logic             snan_a,
  input  logic             snan_b,
  output logic [FP128-1:0] res,
  output logic             invalid
);

  logic             eq, lt, mag_lt, unord, mag_eq;
  logic             cmp_unused;
  logic [FP128-1:0] min_v, max_v, nan_v;

  assign eq         = cmp[0];
  assign lt         = cmp[1];
  assign mag_lt     = cmp[3];
  assign unord      = cmp[4];
  assign cmp_unused = cmp[2];
  assign mag_eq     = ~mag_lt & (a[EMSB:0] == b[EMSB:0]);

  // Equal compare only happens for +0/-0 or identical values; sign picks the zero
  assign min_v = eq ? (a[FP128-1] ? a : b) : (lt ? a : b);
  assign max_v = eq ? (a[FP128-1] ? b : a) : (lt ? b : a);
  assign nan_v = nan_a ? fp128_quiet(a) : (nan_b ? fp128_quiet(b) : FP128_QNAN);

  assign invalid = snan_a | snan_b;

  always_comb begin
    res = min_v;
    if (unord) begin
      res = nan_v;
      if ((op == OP_MINNUM || op == OP_MAXNUM) && (nan_a ^ nan_b)) begin
        if (nan_a && !snan_a)      res = b;
        else if (nan_b && !snan_b) res = a;
      end
    end else begin
      unique case (op)
        OP_MIN, OP_MINNUM: res = min_v;
        OP_MAX, OP_MAXNUM: res = max_v;
        OP_MINMAG:         res = mag_lt ? a : (mag_eq ? min_v : b);
        OP_MAXMAG:         res = mag_lt ? b : (mag_eq ? max_v : a);
        default:           res = min_v;
      endcase
    end
  end

endmodule

// File: rtl/fp_minmax128.sv
// Two-stage valid/ready FP128 min/max pipeline with sticky invalid-operation flag.
module fp_minmax128
  import fp_minmax128_pkg::*;
#(
  parameter int unsigned TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_minmax128_if.slave   bus,
  input  logic            clr_sticky,
  output logic            invalid_sticky
);

  logic             v1, v2, adv1, adv2, s_ready;
  fp_minmax_op_t    s1_op;
  logic [FP128-1:0] s1_a, s1_b;
  logic [4:0]       s1_cmp;
  logic [TAGW-1:0]  s1_tag;
  logic             s1_nan_a, s1_nan_b, s1_snan_a, s1_snan_b;
  logic             in_nan_a, in_nan_b;
  logic [FP128-1:0] sel_res, o_q;
  logic             sel_inv, inv_q;
  logic [TAGW-1:0]  tag_q;
  logic             cmp_unused;

  assign adv2    = v1 & (~v2 | bus.m_ready);
  assign s_ready = ~v1 | adv2;
  assign adv1    = bus.s_valid & s_ready;

  assign bus.s_ready   = s_ready;
  assign bus.m_valid   = v2;
  assign bus.o         = o_q;
  assign bus.o_tag     = tag_q;
  assign bus.o_invalid = inv_q;

  assign in_nan_a   = fp128_is_nan(bus.a);
  assign in_nan_b   = fp128_is_nan(bus.b);
  assign cmp_unused = ^bus.cmp[15:5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      s1_op     <= OP_MIN;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_cmp    <= '0;
      s1_tag    <= '0;
      s1_nan_a  <= 1'b0;
      s1_nan_b  <= 1'b0;
      s1_snan_a <= 1'b0;
      s1_snan_b <= 1'b0;
    end else if (adv1) begin
      v1        <= 1'b1;
      s1_op     <= fp_minmax_op_t'(bus.op);
      s1_a      <= bus.a;
      s1_b      <= bus.b;
      s1_cmp    <= bus.cmp[4:0];
      s1_tag    <= bus.tag;
      s1_nan_a  <= in_nan_a;
      s1_nan_b  <= in_nan_b;
      s1_snan_a <= in_nan_a & ~bus.a[FMSB];
      s1_snan_b <= in_nan_b & ~bus.b[FMSB];
    end else if (adv2) begin
      v1 <= 1'b0;
    end
  end

  fp_minmax_sel128 u_sel (
    .op      (s1_op),
    .a       (s1_a),
    .b       (s1_b),
    .cmp     (s1_cmp),
    .nan_a   (s1_nan_a),
    .nan_b   (s1_nan_b),
    .snan_a  (s1_snan_a),
    .snan_b  (s1_snan_b),
    .res     (sel_res),
    .invalid (sel_inv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      o_q   <= '0;
      tag_q <= '0;
      inv_q <= 1'b0;
    end else if (adv2) begin
      v2    <= 1'b1;
      o_q   <= sel_res;
      tag_q <= s1_tag;
      inv_q <= sel_inv;
    end else if (bus.m_ready) begin
      v2 <= 1'b0;
    end
  end

  // Set on the result handshake dominates a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         invalid_sticky <= 1'b0;
    else if (v2 & bus.m_ready & inv_q)  invalid_sticky <= 1'b1;
    else if (clr_sticky)                invalid_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_fp_minmax128.sv
// Directed bench for fp_minmax128: selection cases, NaN handling, streaming, reset, sticky flag.
module tb_fp_minmax128;
  import fp_minmax128_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr_sticky = 1'b0;
  logic invalid_sticky;
  int unsigned n_assert = 0;
  int unsigned n_fail = 0;

  localparam logic [127:0] P1  = {16'h3FFF, 112'h0};
  localparam logic [127:0] P2  = {16'h4000, 112'h0};
  localparam logic [127:0] P3  = {16'h4000, 1'b1, 111'h0};
  localparam logic [127:0] N1  = {16'hBFFF, 112'h0};
  localparam logic [127:0] N2  = {16'hC000, 112'h0};
  localparam logic [127:0] PZ  = 128'h0;
  localparam logic [127:0] NZ  = {1'b1, 127'h0};
  localparam logic [127:0] QN  = {16'h7FFF, 1'b1, 111'h0};
  localparam logic [127:0] SN  = {16'h7FFF, 112'h1};
  localparam logic [127:0] SNQ = {16'h7FFF, 1'b1, 111'h1};
  localparam logic [15:0]  CMP_LT = 16'h0006;
  localparam logic [15:0]  CMP_EQ = 16'h0005;
  localparam logic [15:0]  CMP_UN = 16'h0010;

  fp_minmax128_if #(.TAGW(4)) bus ();

  fp_minmax128 #(.TAGW(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .clr_sticky     (clr_sticky),
    .invalid_sticky (invalid_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Single op into an empty pipe with m_ready high; returns at the negedge where the result is valid
  task automatic run_op(input string nm, input logic [2:0] op, input logic [127:0] a,
                        input logic [127:0] b, input logic [15:0] cmp, input logic [3:0] tag,
                        input logic [127:0] exp_o, input logic exp_inv);
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.cmp = cmp; bus.tag = tag;
    bus.s_valid = 1'b1; bus.m_ready = 1'b1;
    #1 check({nm, "_sready"}, bus.s_ready, 1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    check({nm, "_mvalid_c1"}, bus.m_valid, 0);
    @(negedge clk);
    check({nm, "_mvalid_c2"}, bus.m_valid, 1);
    check({nm, "_o"}, bus.o, exp_o);
    check({nm, "_tag"}, bus.o_tag, tag);
    check({nm, "_inv"}, bus.o_invalid, exp_inv);
  endtask

  initial begin
    int sent, got, infl;
    bus.s_valid = 1'b0; bus.m_ready = 1'b0; bus.op = '0;
    bus.a = '0; bus.b = '0; bus.cmp = '0; bus.tag = '0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_mvalid", bus.m_valid, 0);
    check("rst_o", bus.o, 0);
    check("rst_otag", bus.o_tag, 0);
    check("rst_oinv", bus.o_invalid, 0);
    check("rst_sticky", invalid_sticky, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("rst_sready", bus.s_ready, 1);

    run_op("min_lt",  3'd0, P1, P2, CMP_LT, 4'd1, P1, 1'b0);
    run_op("min_zero", 3'd0, PZ, NZ, CMP_EQ, 4'd2, NZ, 1'b0);
    run_op("max_zero", 3'd1, PZ, NZ, CMP_EQ, 4'd3, PZ, 1'b0);
    run_op("maxnum_q", 3'd3, QN, P3, CMP_UN, 4'd4, P3, 1'b0);
    @(negedge clk) check("sticky_after_q", invalid_sticky, 0);
    run_op("maxnum_s", 3'd3, SN, P3, CMP_UN, 4'd5, SNQ, 1'b1);
    @(negedge clk) check("sticky_after_s", invalid_sticky, 1);
    run_op("min_snan_b", 3'd0, P1, SN, CMP_UN, 4'd6, SNQ, 1'b1);
    run_op("minmag",   3'd4, N1, P2, 16'h000E, 4'd7, N1, 1'b0);
    run_op("maxmag_tie", 3'd5, N2, P2, CMP_LT, 4'd8, P2, 1'b0);
    run_op("maxmag_a", 3'd5, N2, P1, CMP_LT, 4'd9, N2, 1'b0);

    // Streaming: m_ready follows 1,0,0,1 per cycle while 8 ops are offered back to back
    sent = 0; got = 0; infl = 0;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      @(negedge clk);
      bus.m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      bus.s_valid = (sent < 8);
      bus.op = 3'd0; bus.a = {16'h3FFF, 112'(sent)}; bus.b = P2;
      bus.cmp = CMP_LT; bus.tag = 4'(sent);
      #1;
      check("stream_sready", bus.s_ready, !(infl == 2 && !bus.m_ready));
      if (bus.m_valid && bus.m_ready) begin
        check("stream_tag", bus.o_tag, got);
        check("stream_o", bus.o, {16'h3FFF, 112'(got)});
        got++; infl--;
      end
      if (bus.s_valid && bus.s_ready) begin
        sent++; infl++;
      end
    end
    check("stream_count", got, 8);
    bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset with two ops in flight
    bus.m_ready = 1'b0;
    bus.op = 3'd1; bus.a = P1; bus.b = P2; bus.cmp = CMP_LT; bus.tag = 4'd10;
    bus.s_valid = 1'b1;
    @(negedge clk) bus.tag = 4'd11;
    @(negedge clk) bus.s_valid = 1'b0;
    #1 check("inflight_mvalid", bus.m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_mvalid", bus.m_valid, 0);
    check("midrst_sticky", invalid_sticky, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op("post_rst", 3'd0, P2, P1, 16'h0000, 4'd12, P1, 1'b0);

    run_op("sticky_set", 3'd1, SN, P1, CMP_UN, 4'd13, SNQ, 1'b1);
    @(negedge clk) check("sticky_set_flag", invalid_sticky, 1);
    clr_sticky = 1'b1;
    @(negedge clk) clr_sticky = 1'b0;
    check("sticky_clr", invalid_sticky, 0);
    run_op("sticky_race", 3'd1, SN, P1, CMP_UN, 4'd14, SNQ, 1'b1);
    clr_sticky = 1'b1;
    @(negedge clk) clr_sticky = 1'b0;
    check("sticky_set_wins", invalid_sticky, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
